// File: rtl/fp_norm_pkg.sv
// fp_norm_pkg: shared FSM state and double-precision widths for the mantissa normalizer
package fp_norm_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} norm_state_e;
   localparam int DP_EXP_W  = 11;
   localparam int DP_MANT_W = 64;
   localparam int DP_CNT_W  = 7;
endpackage

// File: rtl/norm_shift_step.sv
// norm_shift_step: one normalization step decode (shift by 2, 1 or stop)
module norm_shift_step
   import fp_norm_pkg::*;
#(
   parameter int MANT_W = DP_MANT_W,
   parameter int EXP_W  = DP_EXP_W
) (
   input  logic [MANT_W-1:0] mant_i,
   input  logic [EXP_W-1:0]  exp_i,
   output logic [MANT_W-1:0] mant_o,
   output logic [EXP_W-1:0]  exp_o,
   output logic [1:0]        step_o,
   output logic              stop_o,
   output logic              zero_o,
   output logic              denorm_o
);
   logic msb, two, one;
   always_comb begin
      zero_o   = mant_i == '0;
      msb      = mant_i[MANT_W-1];
      two      = !zero_o && mant_i[MANT_W-1:MANT_W-2] == 2'b00 && exp_i > EXP_W'(2);
      one      = !zero_o && !msb && !two && exp_i > EXP_W'(1);
      stop_o   = !(two || one);
      denorm_o = !zero_o && !msb && stop_o;
      step_o   = two ? 2'd2 : one ? 2'd1 : 2'd0;
      mant_o   = two ? mant_i << 2 : one ? mant_i << 1 : mant_i;
      exp_o    = exp_i - EXP_W'(step_o);
   end
endmodule

// File: rtl/fp_mant_normalizer.sv
// fp_mant_normalizer: iterative post-normalization of a mantissa/exponent pair
// with valid/ready handshake, one operand in flight.
module fp_mant_normalizer
   import fp_norm_pkg::*;
#(
   parameter int MANT_W = DP_MANT_W,
   parameter int EXP_W  = DP_EXP_W,
   parameter int CNT_W  = DP_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sign,
   input  logic [EXP_W-1:0]  in_exp,
   input  logic [MANT_W-1:0] in_mant,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sign,
   output logic [EXP_W-1:0]  out_exp,
   output logic [MANT_W-1:0] out_mant,
   output logic [CNT_W-1:0]  out_shift,
   output logic              out_denorm,
   output logic              out_zero
);
   norm_state_e       state_q;
   logic              sign_q, zero_q, denorm_q;
   logic [EXP_W-1:0]  exp_q, exp_d;
   logic [MANT_W-1:0] mant_q, mant_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [1:0]        step_d;
   logic              stop_d, zero_d, denorm_d;

   norm_shift_step #(.MANT_W(MANT_W), .EXP_W(EXP_W)) u_step (
      .mant_i(mant_q), .exp_i(exp_q), .mant_o(mant_d), .exp_o(exp_d),
      .step_o(step_d), .stop_o(stop_d), .zero_o(zero_d), .denorm_o(denorm_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         sign_q   <= 1'b0;
         exp_q    <= '0;
         mant_q   <= '0;
         cnt_q    <= '0;
         zero_q   <= 1'b0;
         denorm_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               state_q  <= SHIFT;
               sign_q   <= in_sign;
               exp_q    <= in_exp;
               mant_q   <= in_mant;
               cnt_q    <= '0;
               zero_q   <= 1'b0;
               denorm_q <= 1'b0;
            end
            SHIFT: if (stop_d) begin
               state_q  <= DONE;
               zero_q   <= zero_d;
               denorm_q <= denorm_d;
            end else begin
               mant_q <= mant_d;
               exp_q  <= exp_d;
               cnt_q  <= cnt_q + CNT_W'(step_d);
            end
            DONE: if (out_ready) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready   = state_q == IDLE;
   assign out_valid  = state_q == DONE;
   assign out_sign   = sign_q;
   assign out_exp    = (zero_q || denorm_q) ? '0 : exp_q;
   assign out_mant   = mant_q;
   assign out_shift  = cnt_q;
   assign out_denorm = denorm_q;
   assign out_zero   = zero_q;
endmodule

// File: tb/tb_fp_mant_normalizer.sv
// tb_fp_mant_normalizer: directed vectors with hand-computed results
module tb_fp_mant_normalizer;
   logic        clk = 1'b0, rst = 1'b1;
   logic        in_valid = 1'b0, in_ready, in_sign = 1'b0;
   logic [10:0] in_exp = '0, out_exp;
   logic [63:0] in_mant = '0, out_mant;
   logic        out_valid, out_ready = 1'b0, out_sign, out_denorm, out_zero;
   logic [6:0]  out_shift;
   int          n_cmp = 0, n_bad = 0;

   fp_mant_normalizer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
      .in_exp(in_exp), .in_mant(in_mant), .out_valid(out_valid), .out_ready(out_ready),
      .out_sign(out_sign), .out_exp(out_exp), .out_mant(out_mant), .out_shift(out_shift),
      .out_denorm(out_denorm), .out_zero(out_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   task automatic accept(input logic s, input logic [10:0] e, input logic [63:0] m);
      in_sign = s; in_exp = e; in_mant = m; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic run(input string tag, input logic s, input logic [10:0] e, input logic [63:0] m,
                      input int lat, input logic [63:0] xm, input logic [10:0] xe,
                      input logic [6:0] xs, input logic xd, input logic xz, input int hold);
      int n = 0;
      chk({tag, ".in_ready"}, in_ready, 1'b1);
      accept(s, e, m);
      while (!out_valid && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!out_valid) begin
         chk({tag, ".timeout"}, 1'b0, 1'b1);
         return;
      end
      chk({tag, ".latency"}, 64'(n + 1), 64'(lat));
      for (int i = 0; i <= hold; i++) begin
         chk({tag, ".mant"}, out_mant, xm);
         chk({tag, ".exp"}, out_exp, xe);
         chk({tag, ".shift"}, out_shift, xs);
         chk({tag, ".sign"}, out_sign, s);
         chk({tag, ".denorm"}, out_denorm, xd);
         chk({tag, ".zero"}, out_zero, xz);
         chk({tag, ".valid_hold"}, out_valid, 1'b1);
         chk({tag, ".busy"}, in_ready, 1'b0);
         if (i < hold) begin @(posedge clk); #1; end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, ".idle_rdy"}, in_ready, 1'b1);
      chk({tag, ".idle_vld"}, out_valid, 1'b0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst.in_ready", in_ready, 1'b1);
      chk("rst.out_valid", out_valid, 1'b0);
      chk("rst.mant", out_mant, 64'h0);
      chk("rst.shift", out_shift, 7'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      run("norm",  1'b0, 11'd1023, 64'h8000_0000_0000_0000, 2,  64'h8000_0000_0000_0000, 11'd1023, 7'd0, 1'b0, 1'b0, 0);
      run("one",   1'b0, 11'd1023, 64'h1,                   34, 64'h8000_0000_0000_0000, 11'd960,  7'd63, 1'b0, 1'b0, 0);
      run("dn5",   1'b1, 11'd5,    64'h1,                   4,  64'h10,                  11'd0,    7'd4, 1'b1, 1'b0, 0);
      run("zero",  1'b1, 11'd700,  64'h0,                   2,  64'h0,                   11'd0,    7'd0, 1'b0, 1'b1, 0);
      run("hold",  1'b0, 11'd10,   64'h2000_0000_0000_0000, 3,  64'h8000_0000_0000_0000, 11'd8,    7'd2, 1'b0, 1'b0, 5);
      run("e0msb", 1'b0, 11'd0,    64'hC000_0000_0000_0000, 2,  64'hC000_0000_0000_0000, 11'd0,    7'd0, 1'b0, 1'b0, 0);
      run("e0dn",  1'b1, 11'd0,    64'h1,                   2,  64'h1,                   11'd0,    7'd0, 1'b1, 1'b0, 0);
      run("e2",    1'b0, 11'd2,    64'h1,                   3,  64'h2,                   11'd0,    7'd1, 1'b1, 1'b0, 0);
      accept(1'b0, 11'd1023, 64'h1);
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst.out_valid", out_valid, 1'b0);
      chk("midrst.in_ready", in_ready, 1'b1);
      chk("midrst.mant", out_mant, 64'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run("after", 1'b0, 11'd20, 64'h4000_0000_0000_0000, 3, 64'h8000_0000_0000_0000, 11'd19, 7'd1, 1'b0, 1'b0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/fp_mant_normalizer.md
Name: fp_mant_normalizer

Overview:
- Sequential post-normalization stage for the double-precision datapath. Sits directly upstream of the fixed left-shift-by-2 unit's consumers.
- Takes an unnormalized 64-bit mantissa and its exponent from the add/multiply core.
- Iteratively left-shifts by 2 or 1 per cycle until mantissa MSB is set, decrementing the exponent. Stops early on zero or exponent floor, flagging denormal/zero.
- Valid/ready handshake on both sides; one operand in flight at a time.

Parameters:
- MANT_W, 64, mantissa register width (bits).
- EXP_W, 11, exponent width (IEEE754 double).
- CNT_W, 7, width of shift-count output (must hold MANT_W-1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand present.
- in_ready  output  1  block can accept (high only in IDLE).
- in_sign  input  1  sign, passed through.
- in_exp  input  EXP_W  biased exponent.
- in_mant  input  MANT_W  unnormalized mantissa.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts.
- out_sign  output  1  registered sign.
- out_exp  output  EXP_W  normalized biased exponent; 0 when denorm or zero.
- out_mant  output  MANT_W  normalized mantissa.
- out_shift  output  CNT_W  total left-shift positions applied.
- out_denorm  output  1  result nonzero but MSB clear (exponent floor hit).
- out_zero  output  1  mantissa is zero.

Behaviour:
- Reset (async, any state, including mid-shift): state=IDLE; all outputs and internal registers 0, except in_ready=1. An operand in flight is discarded.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, load sign/exp/mant, clear shift count, go to SHIFT.
- SHIFT: in_ready=0, out_valid=0. Each cycle evaluates the registered mant/exp:
  - mant==0: zero=1, go to DONE.
  - mant[MANT_W-1]==1: go to DONE.
  - mant[MANT_W-1:MANT_W-2]==00 and exp>2: mant<<=2, exp-=2, cnt+=2.
  - else if mant[MANT_W-1]==0 and exp>1: mant<<=1, exp-=1, cnt+=1.
  - else (exp<=1): go to DONE with denorm=1.
- DONE: out_valid=1; outputs stable until out_ready. On out_valid&out_ready, go to IDLE. No same-cycle reload; the next accept occurs in IDLE.
- Output encoding in DONE:
  - out_exp=0 if zero or denorm, else the exp register.
  - out_mant = mant register.
  - out_sign passes through unchanged, including for zero.
- Latency, accept at cycle t with k shift cycles: out_valid rises at t+k+2. An already-normalized input gives out_valid at t+2.
- Input exp=0: no shifts permitted. Result is denorm if mant nonzero with MSB clear. If MSB set, result is normal with out_exp=0.
- Shift bits in are zero. The exponent never goes below 1 during shifting (no wrap-around).
- in_valid while not IDLE is ignored. Upstream must hold the operand until in_ready.

Decomposition:
- Package fp_norm_pkg holds:
  - state enum (IDLE/SHIFT/DONE);
  - constants DP_EXP_W=11, DP_MANT_W=64, DP_CNT_W=7.
- One combinational sub-module, norm_shift_step:
  - inputs: mant and exp;
  - outputs: next mant, next exp, step amount (0/1/2), stop/zero/denorm decode.
- The FSM and registers stay in the top module.

Test Plan:
- mant=0x8000_0000_0000_0000, exp=1023, accepted at t -> out_valid at t+2; mant unchanged; exp=1023; shift=0; denorm=0; zero=0.
- mant=0x0000_0000_0000_0001, exp=1023 -> 32 shift cycles; out_valid at t+34; mant=0x8000_0000_0000_0000; exp=960; shift=63.
- mant=0x0000_0000_0000_0001, exp=5 -> mant=0x10; out_exp=0; shift=4; denorm=1; out_valid at t+4.
- mant=0, exp=700, sign=1 -> out_valid at t+2; zero=1; out_exp=0; out_sign=1; shift=0.
- mant=0x2000_0000_0000_0000, exp=10, out_ready held low 5 cycles after out_valid -> outputs stable (mant=0x8000_0000_0000_0000, exp=8, shift=2); in_ready=0 throughout; IDLE one cycle after out_ready.
- rst pulsed mid-SHIFT on the 0x1 operand -> out_valid=0 and in_ready=1 immediately. A new operand (0x4000_0000_0000_0000, exp=20) then yields exp=19, shift=1.
